// File: rtl/plab5_mcore_sec_mem_responder.sv
// Word-addressed memory behind a val/rdy request/response port. When mode is set, non-secure
// requesters may only WRITE_INIT words at or above p_secure_base; everything else is denied.
module plab5_mcore_sec_mem_responder #(
    parameter int p_mem_opaque_nbits = 8,
    parameter int p_mem_addr_nbits   = 32,
    parameter int p_mem_data_nbits   = 32,
    parameter int p_num_words        = 256,
    parameter int p_secure_base      = 128,
    localparam int c_rqc = 3 + p_mem_opaque_nbits + p_mem_addr_nbits + 2,
    localparam int c_rsc = 3 + p_mem_opaque_nbits + 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        mode,
    input  logic [c_rqc-1:0]            req_msg_control,
    input  logic [p_mem_data_nbits-1:0] req_msg_data,
    input  logic                        req_domain,
    input  logic                        req_val,
    output logic                        req_rdy,
    output logic [c_rsc-1:0]            resp_msg_control,
    output logic [p_mem_data_nbits-1:0] resp_msg_data,
    output logic                        resp_domain,
    output logic                        resp_val,
    input  logic                        resp_rdy,
    output logic                        resp_fail
);

    localparam int c_idx_nbits = $clog2(p_num_words);
    localparam int c_nbytes    = p_mem_data_nbits / 8;
    localparam logic [c_idx_nbits:0] c_secure_base = (c_idx_nbits + 1)'(p_secure_base);
    localparam logic [2:0] c_type_write = 3'd1;
    localparam logic [2:0] c_type_winit = 3'd2;

    // Handshake: a transfer occurs on a rising edge where both val and rdy are high; a
    // presented response holds every output unchanged until it transfers.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic w_req_rdy;
    logic w_req_fire;
    logic w_resp_val;
    logic w_access;

    logic [2:0]                    r_req_type;
    logic [p_mem_opaque_nbits-1:0] r_req_opaque;
    logic [c_idx_nbits-1:0]        r_req_idx;
    logic [1:0]                    r_req_len;
    logic [p_mem_data_nbits-1:0]   r_req_data;
    logic                          r_req_domain;

    logic [c_rsc-1:0]            r_resp_control;
    logic [p_mem_data_nbits-1:0] r_resp_data;
    logic                        r_resp_domain;
    logic                        r_resp_fail;

    logic [p_mem_data_nbits-1:0] r_mem [p_num_words];

    logic                        w_is_write;
    logic                        w_deny;
    logic                        w_mem_we;
    logic [c_nbytes-1:0]         w_byte_mask;
    logic [p_mem_data_nbits-1:0] w_read_data;

    // Address bits outside the word index are intentionally ignored.
    logic w_unused_ctl;
    assign w_unused_ctl = ^req_msg_control;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_req_fire) w_state_next = ST_ACCESS;
            ST_ACCESS: w_state_next = ST_RESP;
            ST_RESP: begin
                if (resp_rdy) w_state_next = w_req_fire ? ST_ACCESS : ST_IDLE;
            end
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_req_rdy  = (r_state == ST_IDLE) || ((r_state == ST_RESP) && resp_rdy);
        w_resp_val = (r_state == ST_RESP);
        w_access   = (r_state == ST_ACCESS);
        w_req_fire = req_val && w_req_rdy;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_type   <= '0;
            r_req_opaque <= '0;
            r_req_idx    <= '0;
            r_req_len    <= '0;
            r_req_data   <= '0;
            r_req_domain <= 1'b0;
        end else if (w_req_fire) begin
            r_req_type   <= req_msg_control[c_rqc-1 -: 3];
            r_req_opaque <= req_msg_control[2 + p_mem_addr_nbits +: p_mem_opaque_nbits];
            r_req_idx    <= req_msg_control[4 +: c_idx_nbits];
            r_req_len    <= req_msg_control[1:0];
            r_req_data   <= req_msg_data;
            r_req_domain <= req_domain;
        end
    end

    always_comb begin
        w_is_write  = (r_req_type == c_type_write) || (r_req_type == c_type_winit);
        w_deny      = mode && !r_req_domain && ({1'b0, r_req_idx} >= c_secure_base)
                      && (r_req_type != c_type_winit);
        w_mem_we    = w_access && w_is_write && !w_deny && !reset;
        w_byte_mask = '0;
        w_read_data = '0;
        for (int b = 0; b < c_nbytes; b++) begin
            w_byte_mask[b] = (r_req_len == 2'd0) || (b < int'(r_req_len));
            if (w_byte_mask[b]) w_read_data[8*b +: 8] = r_mem[r_req_idx][8*b +: 8];
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < c_nbytes; b++) begin
                if (w_byte_mask[b]) r_mem[r_req_idx][8*b +: 8] <= r_req_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_resp_control <= '0;
            r_resp_data    <= '0;
            r_resp_domain  <= 1'b0;
            r_resp_fail    <= 1'b0;
        end else if (w_access) begin
            r_resp_control <= {r_req_type, r_req_opaque, r_req_len};
            r_resp_data    <= (w_deny || w_is_write) ? '0 : w_read_data;
            r_resp_domain  <= r_req_domain;
            r_resp_fail    <= w_deny;
        end
    end

    assign req_rdy          = w_req_rdy;
    assign resp_val         = w_resp_val;
    assign resp_msg_control = r_resp_control;
    assign resp_msg_data    = r_resp_data;
    assign resp_domain      = r_resp_domain;
    assign resp_fail        = r_resp_fail;

endmodule

// File: doc/plab5_mcore_sec_mem_responder.md
PLAB5_MCORE_SEC_MEM_RESPONDER -- requirements
Module: plab5_mcore_sec_mem_responder

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- p_mem_opaque_nbits, 8, opaque width o
- p_mem_addr_nbits, 32, address width a
- p_mem_data_nbits, 32, data width d
- p_num_words, 256, storage depth
- p_secure_base, 128, first word index of the secure region
REQ-002 SHALL derive rqc = 3+o+a+2, rqd = d, rsc = 3+o+2, rsd = d.
REQ-003 SHALL have ports (name, direction, width, meaning), one per line; clock and reset are listed first:
- clk, in, 1, sole clock
- reset, in, 1, synchronous, active-high
- mode, in, 1, 1 = secure checking enabled; 0 = checks bypassed
- req_msg_control, in, rqc, {type[2:0], opaque, addr, len[1:0]}, MSB first
- req_msg_data, in, rqd, write data
- req_domain, in, 1, requester domain (1 = secure)
- req_val, in, 1, request valid
- req_rdy, out, 1, request ready
- resp_msg_control, out, rsc, {type, opaque, len}
- resp_msg_data, out, rsd, read data
- resp_domain, out, 1, echoed request domain
- resp_val, out, 1, response valid
- resp_rdy, in, 1, response ready
- resp_fail, out, 1, access denied

Function
REQ-004 SHALL be one clock, synchronous active-high reset; no other clocks or async logic.
REQ-005 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-006 SHALL drive req_rdy = (state==IDLE) || (state==RESP && resp_rdy).
REQ-007 SHALL latch control, data and domain into a request register on req_val && req_rdy, then go to ACCESS.
REQ-008 SHALL, in ACCESS, perform the storage access in exactly one cycle, load the response register, then go to RESP.
REQ-009 SHALL assert resp_val only in RESP, and hold all response outputs stable until resp_rdy.
REQ-010 SHALL, in RESP with resp_rdy: go to ACCESS if a new request fires the same cycle, otherwise go to IDLE.
REQ-011 SHALL have latency of exactly 2 cycles from request fire to resp_val, and a throughput of 1 request per 2 cycles under continuous resp_rdy.
REQ-012 SHALL compute the word index as addr[2 +: clog2(p_num_words)]; higher address bits and addr[1:0] are ignored.
REQ-013 SHALL treat type 0 as READ, 1 as WRITE, 2 as WRITE_INIT; any other type is handled as READ.
REQ-014 SHALL deny a request (deny = 1) when mode==1 && req_domain==0 && index >= p_secure_base && type != WRITE_INIT.
REQ-015 SHALL, on a denied request: suppress any write, set resp_msg_data = 0 and resp_fail = 1.
REQ-016 SHALL, on a permitted WRITE or WRITE_INIT with len==0, write the full word.
REQ-017 SHALL, on a permitted WRITE or WRITE_INIT with len==n (n = 1..3), write only bytes [n-1:0] and leave the rest unchanged.
REQ-018 SHALL, on a permitted READ, return the word with bytes at and above len zeroed when len != 0, or the full word when len == 0.
REQ-019 SHALL set resp_msg_data = 0 for write responses.
REQ-020 SHALL echo type, opaque, len and domain from the request into the response; resp_fail = 0 unless denied.
REQ-021 SHALL, when mode==0, never deny, regardless of domain.
REQ-022 SHALL sample mode in ACCESS; a mode change while in RESP does not alter a pending response.
REQ-023 SHALL make a READ following a WRITE to the same index observe the written value.

Reset
REQ-024 SHALL, on reset, force state to IDLE and drive resp_val = 0, resp_fail = 0, resp_domain = 0, resp_msg_control = 0 and resp_msg_data = 0; req_rdy is 1 from the first cycle after reset.
REQ-025 SHALL, on reset asserted in ACCESS or RESP, discard the pending request and produce no response.
REQ-026 SHALL NOT reset storage contents.
REQ-027 SHALL NOT let a write whose ACCESS cycle coincides with reset modify storage.

Verification
REQ-028 SHALL pass: mode=1, dom=1, WRITE idx 200, data 0xDEADBEEF, len 0, then READ idx 200 -> read resp data 0xDEADBEEF, fail 0, dom 1, resp_val exactly 2 cycles after each fire.
REQ-029 SHALL pass: mode=1, dom=0, READ idx 200 -> data 0, fail 1; then dom=0 WRITE 0x1 to idx 200, then dom=1 READ -> still 0xDEADBEEF.
REQ-030 SHALL pass: mode=0, dom=0, WRITE 0x12345678 to idx 130, then READ -> 0x12345678, fail 0; WRITE_INIT by dom=0 with mode=1 succeeds.
REQ-031 SHALL pass: WRITE 0xAABBCCDD to idx 5, then WRITE len 1, data 0x11, then READ len 0 -> 0xAABBCC11; READ len 2 -> 0x0000CC11.
REQ-032 SHALL pass: resp_rdy held 0 for 5 cycles -> outputs stable and req_rdy=0; back-to-back requests with resp_rdy=1 -> one response every 2 cycles, opaque order preserved.
REQ-033 SHALL pass: reset asserted in the ACCESS cycle of a WRITE -> no response, storage unchanged, req_rdy=1 on the next cycle.
